data_mem_ctrl: RTL and testbench



---
 rtl/data_mem_ctrl_pkg.sv | 45 ++++
 rtl/data_mem_ctrl_if.sv | 36 +++
 rtl/dmem_lane_align.sv | 49 ++++
 rtl/data_mem_ctrl.sv | 128 ++++++++++++
 tb/tb_data_mem_ctrl.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_ctrl_pkg.sv
// Data memory controller shared types.
// FUNC3 encodings, FSM states and size helpers.
package data_mem_ctrl_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } size_t;

  // Unlisted codes fall back to word size.
  function automatic size_t f3_size(
    input logic [2:0] f3
  );
    unique case (f3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      default:     return SZ_W;
    endcase
  endfunction

  function automatic logic is_misaligned(
    input logic [2:0] f3,
    input logic [1:0] a
  );
    unique case (f3_size(f3))
      SZ_H:    return a[0];
      SZ_W:    return |a;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// EX/MEM stage to data memory controller bus.
// Requests flow in, stall and load result flow back.
interface data_mem_ctrl_if;

  logic        MEM_READ_EN;
  logic        MEM_WRITE_EN;
  logic [31:0] ADDR;
  logic [31:0] WRITE_DATA;
  logic [2:0]  FUNC3;
  logic        MEM_BUSYWAIT;
  logic [31:0] READ_DATA;
  logic        MISALIGNED;

  modport master (
    output MEM_READ_EN,
    output MEM_WRITE_EN,
    output ADDR,
    output WRITE_DATA,
    output FUNC3,
    input  MEM_BUSYWAIT,
    input  READ_DATA,
    input  MISALIGNED
  );

  modport slave (
    input  MEM_READ_EN,
    input  MEM_WRITE_EN,
    input  ADDR,
    input  WRITE_DATA,
    input  FUNC3,
    output MEM_BUSYWAIT,
    output READ_DATA,
    output MISALIGNED
  );

endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for stores and
// extract/extend for loads.
module dmem_lane_align
  import data_mem_ctrl_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  func3,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wlane,
  output logic [31:0] rdata
);

  size_t size;
  logic  sx;
  logic [7:0]  b;
  logic [15:0] h;

  assign size = f3_size(func3);
  assign sx   = ~func3[2];

  // Replicate store data across lanes and pick the load slice.
  always_comb begin
    be    = 4'b1111;
    wlane = wdata;
    rdata = rword;
    b     = rword[{addr_lo, 3'b000} +: 8];
    h     = addr_lo[1] ? rword[31:16] : rword[15:0];
    unique case (size)
      SZ_B: begin
        be    = 4'b0001 << addr_lo;
        wlane = {4{wdata[7:0]}};
        rdata = {{24{sx & b[7]}}, b};
      end
      SZ_H: begin
        be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wdata[15:0]}};
        rdata = {{16{sx & h[15]}}, h};
      end
      default: begin
        be    = 4'b1111;
        wlane = wdata;
        rdata = rword;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Multi-cycle data memory controller with
// fixed latency, byte lanes and alignment check.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int MEM_LATENCY = 3,
  parameter int DEPTH_WORDS = 256
) (
  input logic           CLK,
  input logic           RESET,
  data_mem_ctrl_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [2:0]    func3_q;
  logic          store_q;
  logic [31:0]   read_data_q;
  logic          misaligned_q;

  logic req, mis, busy, start, reject, exec, mem_we;
  logic [AW-1:0] idx;
  logic [31:0]   rword, wlane, rdata;
  logic [3:0]    be;
  logic          addr_unused;

  logic [31:0] mem [DEPTH_WORDS];

  assign req = bus.MEM_READ_EN | bus.MEM_WRITE_EN;
  assign mis = is_misaligned(bus.FUNC3, bus.ADDR[1:0]);
  assign addr_unused = ^bus.ADDR[31:AW+2];

  assign idx    = addr_q[AW+1:2];
  assign rword  = mem[idx];
  assign mem_we = exec & store_q & ~RESET;

  dmem_lane_align u_align (
    .addr_lo (addr_q[1:0]),
    .func3   (func3_q),
    .wdata   (wdata_q),
    .rword   (rword),
    .be      (be),
    .wlane   (wlane),
    .rdata   (rdata)
  );

  // Next state, counter and combinational stall.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy    = 1'b0;
    start   = 1'b0;
    reject  = 1'b0;
    exec    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          busy = 1'b1;
          if (mis) begin
            reject  = 1'b1;
            state_d = S_DONE;
          end else begin
            start   = 1'b1;
            cnt_d   = 4'(MEM_LATENCY - 1);
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        busy = 1'b1;
        if (cnt_q == 4'd0) begin
          exec    = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, latched request and result registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      func3_q      <= '0;
      store_q      <= 1'b0;
      read_data_q  <= '0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      misaligned_q <= reject;
      if (start) begin
        addr_q  <= bus.ADDR[AW+1:0];
        wdata_q <= bus.WRITE_DATA;
        func3_q <= bus.FUNC3;
        store_q <= bus.MEM_WRITE_EN;
      end
      if (reject && !bus.MEM_WRITE_EN)
        read_data_q <= '0;
      if (exec && !store_q)
        read_data_q <= rdata;
    end
  end

  // Byte-enabled array write, contents survive reset.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++)
        if (be[i])
          mem[idx][8*i +: 8] <= wlane[8*i +: 8];
    end
  end

  assign bus.MEM_BUSYWAIT = busy;
  assign bus.READ_DATA    = read_data_q;
  assign bus.MISALIGNED   = misaligned_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Testbench for data_mem_ctrl.
// Directed table, corner sequences, random vs model.
module tb_data_mem_ctrl;

  localparam int LAT = 3;

  logic clk;
  logic rst;

  data_mem_ctrl_if bus ();

  data_mem_ctrl #(
    .MEM_LATENCY (LAT),
    .DEPTH_WORDS (256)
  ) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] a;
    logic [31:0] wd;
    logic [2:0]  f3;
    logic [31:0] exp_rd;
    logic        exp_mis;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  mb [1024];
  logic [31:0] rd_prev = 32'h0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Byte-addressed reference: 1 KiB image, address taken modulo 1024.
  task automatic model(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [2:0] f3,
                       output logic mis, output logic [31:0] exp_rd);
    int n;
    int base;
    logic [31:0] v;
    n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    base = int'(a[9:0]);
    mis = (base % n) != 0;
    if (wr) begin
      if (!mis)
        for (int k = 0; k < n; k++) mb[base + k] = wd[8*k +: 8];
    end else if (rd) begin
      if (mis) begin
        rd_prev = 32'h0;
      end else begin
        v = 32'h0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = mb[base + k];
        if (n == 1 && !f3[2]) v = {{24{v[7]}}, v[7:0]};
        if (n == 2 && !f3[2]) v = {{16{v[15]}}, v[15:0]};
        rd_prev = v;
      end
    end
    exp_rd = rd_prev;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [2:0] f3);
    bus.MEM_READ_EN  = rd;
    bus.MEM_WRITE_EN = wr;
    bus.ADDR         = a;
    bus.WRITE_DATA   = wd;
    bus.FUNC3        = f3;
  endtask

  // Count stalled cycles until the first non-stalled one.
  task automatic wait_done(input string nm, output int n, output bit ok);
    n = 0;
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!bus.MEM_BUSYWAIT) begin
        ok = 1'b1;
        break;
      end
      n++;
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s:timeout got busy %0d cycles required completion", nm, n);
    end
  endtask

  task automatic run(input logic rd, input logic wr, input logic [31:0] a,
                     input logic [31:0] wd, input logic [2:0] f3,
                     input logic [31:0] exp_rd, input logic exp_mis, input string nm);
    int n;
    bit ok;
    drive(rd, wr, a, wd, f3);
    wait_done(nm, n, ok);
    if (ok) begin
      check({nm, ":busy"}, n, exp_mis ? 32'd1 : 32'(LAT + 1));
      check({nm, ":mis"}, {31'h0, bus.MISALIGNED}, {31'h0, exp_mis});
      check({nm, ":rdata"}, bus.READ_DATA, exp_rd);
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    @(posedge clk);
    #1;
    check({nm, ":idle_mis"}, {31'h0, bus.MISALIGNED}, 32'h0);
  endtask

  vec_t tbl [20];

  function automatic vec_t mk(logic rd, logic wr, logic [31:0] a, logic [31:0] wd,
                              logic [2:0] f3, logic [31:0] e, logic m);
    vec_t v;
    v.rd = rd; v.wr = wr; v.a = a; v.wd = wd; v.f3 = f3;
    v.exp_rd = e; v.exp_mis = m;
    return v;
  endfunction

  initial begin
    logic m;
    logic [31:0] e;
    logic [31:0] a, wd;
    logic [2:0] f3;
    logic rd, wr;
    int n;
    bit ok;
    int sel;

    tbl[0]  = mk(0, 1, 32'h010, 32'hDEADBEEF, 3'b010, 32'h00000000, 0);
    tbl[1]  = mk(1, 0, 32'h010, 32'h0,        3'b010, 32'hDEADBEEF, 0);
    tbl[2]  = mk(0, 1, 32'h010, 32'h0,        3'b010, 32'hDEADBEEF, 0);
    tbl[3]  = mk(0, 1, 32'h013, 32'h00000080, 3'b000, 32'hDEADBEEF, 0);
    tbl[4]  = mk(1, 0, 32'h013, 32'h0,        3'b000, 32'hFFFFFF80, 0);
    tbl[5]  = mk(1, 0, 32'h013, 32'h0,        3'b100, 32'h00000080, 0);
    tbl[6]  = mk(1, 0, 32'h010, 32'h0,        3'b010, 32'h80000000, 0);
    tbl[7]  = mk(0, 1, 32'h012, 32'h00008001, 3'b001, 32'h80000000, 0);
    tbl[8]  = mk(1, 0, 32'h012, 32'h0,        3'b001, 32'hFFFF8001, 0);
    tbl[9]  = mk(1, 0, 32'h012, 32'h0,        3'b101, 32'h00008001, 0);
    tbl[10] = mk(1, 0, 32'h011, 32'h0,        3'b001, 32'h00000000, 1);
    tbl[11] = mk(1, 0, 32'h010, 32'h0,        3'b010, 32'h80010000, 0);
    tbl[12] = mk(0, 1, 32'h400, 32'hA5A5A5A5, 3'b010, 32'h80010000, 0);
    tbl[13] = mk(1, 0, 32'h000, 32'h0,        3'b010, 32'hA5A5A5A5, 0);
    tbl[14] = mk(1, 1, 32'h014, 32'h0BADF00D, 3'b010, 32'hA5A5A5A5, 0);
    tbl[15] = mk(1, 0, 32'h014, 32'h0,        3'b010, 32'h0BADF00D, 0);
    tbl[16] = mk(0, 1, 32'h015, 32'hFFFFFF77, 3'b100, 32'h0BADF00D, 0);
    tbl[17] = mk(1, 0, 32'h014, 32'h0,        3'b111, 32'h0BAD770D, 0);
    tbl[18] = mk(0, 1, 32'h016, 32'h11111111, 3'b010, 32'h0BAD770D, 1);
    tbl[19] = mk(1, 0, 32'h014, 32'h0,        3'b110, 32'h0BAD770D, 0);

    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    repeat (3) @(posedge clk);
    #1;
    check("rst:busy", {31'h0, bus.MEM_BUSYWAIT}, 32'h0);
    check("rst:rdata", bus.READ_DATA, 32'h0);
    check("rst:mis", {31'h0, bus.MISALIGNED}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      model(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].f3, m, e);
      run(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].f3,
          tbl[i].exp_rd, tbl[i].exp_mis, $sformatf("tbl%0d", i));
    end

    // Request held through DONE: one access, then a fresh one from IDLE.
    model(1'b1, 1'b0, 32'h010, 32'h0, 3'b010, m, e);
    drive(1'b1, 1'b0, 32'h010, 32'h0, 3'b010);
    wait_done("hold1", n, ok);
    if (ok) begin
      check("hold1:busy", n, 32'(LAT + 1));
      check("hold1:rdata", bus.READ_DATA, 32'h80010000);
    end
    wait_done("hold2", n, ok);
    if (ok) check("hold2:busy", n, 32'(LAT + 1));
    drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    @(posedge clk);
    #1;

    // Reset on second ACCESS cycle aborts the store.
    model(1'b0, 1'b1, 32'h020, 32'h11112222, 3'b010, m, e);
    run(1'b0, 1'b1, 32'h020, 32'h11112222, 3'b010, e, m, "pre_rst");
    drive(1'b0, 1'b1, 32'h020, 32'h12345678, 3'b010);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    #1;
    check("abort:busy", {31'h0, bus.MEM_BUSYWAIT}, 32'h0);
    check("abort:rdata", bus.READ_DATA, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    rd_prev = 32'h0;
    @(posedge clk);
    #1;
    model(1'b1, 1'b0, 32'h020, 32'h0, 3'b010, m, e);
    run(1'b1, 1'b0, 32'h020, 32'h0, 3'b010, e, m, "post_rst");

    // Give every word in the random window a known value.
    for (int w = 0; w < 16; w++) begin
      wd = $urandom;
      model(1'b0, 1'b1, 32'(w * 4), wd, 3'b010, m, e);
      run(1'b0, 1'b1, 32'(w * 4), wd, 3'b010, e, m, $sformatf("fill%0d", w));
    end

    for (int i = 0; i < 80; i++) begin
      sel = $urandom_range(1, 3);
      rd = (sel != 2);
      wr = (sel != 1);
      a  = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
      wd = $urandom;
      f3 = 3'($urandom_range(0, 7));
      model(rd, wr, a, wd, f3, m, e);
      run(rd, wr, a, wd, f3, e, m, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
